// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: memory read handshake, redirect input and decoder-side instruction stream.
// master = fetch unit, slave = memory/decoder environment.
interface instruction_fetch_unit_if;
    logic [31:0] mem_address;
    logic        mem_request;
    logic        mem_ack;
    logic [31:0] mem_read_data;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;
    logic        instruction_valid;
    logic        instruction_ready;
    logic        misaligned_fault;

    modport master (
        output mem_address, mem_request, instruction, instruction_pc,
               instruction_valid, misaligned_fault,
        input  mem_ack, mem_read_data, redirect, redirect_target, instruction_ready
    );

    modport slave (
        input  mem_address, mem_request, instruction, instruction_pc,
               instruction_valid, misaligned_fault,
        output mem_ack, mem_read_data, redirect, redirect_target, instruction_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, single-outstanding memory read, {word, pc} FIFO toward the decoder.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect raises a sticky fault and halts fetch.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    instruction_fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // state     | meaning
    // S_IDLE    | no request outstanding; issue one next cycle if FIFO has room
    // S_WAIT    | request outstanding, data will be kept
    // S_DISCARD | request outstanding after a redirect, data will be dropped
    // S_HALT    | alignment fault; no more requests until reset
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD, S_HALT} state_t;

    state_t         state_q;
    logic [31:0]    pc_q;
    logic [31:0]    mem_addr_q;
    logic           mem_req_q;
    logic           fault_q;
    logic [31:0]    word_q [DEPTH];
    logic [31:0]    wpc_q  [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;

    logic [31:0]    target;
    logic           misaligned;
    logic           redirect_act;
    logic           push;
    logic           pop;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target     = bus.redirect_target;
    assign misaligned = (bus.redirect_target[1:0] != 2'b00);
`else
    assign target     = {bus.redirect_target[31:2], 2'b00};
    assign misaligned = 1'b0;
`endif

    // A halted unit ignores redirects; only reset restarts it.
    assign redirect_act = bus.redirect && (state_q != S_HALT);
    assign push         = (state_q == S_WAIT) && bus.mem_ack && !bus.redirect;
    assign pop          = (count_q != '0) && bus.instruction_ready && !redirect_act;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.redirect) begin
                        pc_q <= target;
                        if (misaligned) begin
                            fault_q <= 1'b1;
                            state_q <= S_HALT;
                        end
                    end else if (count_q < CW'(DEPTH)) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_q;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.redirect) begin
                        pc_q <= target;
                        if (misaligned) fault_q <= 1'b1;
                        if (bus.mem_ack) begin
                            mem_req_q <= 1'b0;
                            state_q   <= misaligned ? S_HALT : S_IDLE;
                        end else begin
                            state_q   <= S_DISCARD;
                        end
                    end else if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        pc_q      <= pc_q + 32'd4;
                        state_q   <= S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (bus.redirect) begin
                        pc_q <= target;
                        if (misaligned) fault_q <= 1'b1;
                    end
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= (fault_q || (bus.redirect && misaligned)) ? S_HALT : S_IDLE;
                    end
                end
                S_HALT: begin
                    mem_req_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                wpc_q[i]  <= '0;
            end
        end else if (redirect_act) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                word_q[wr_ptr_q] <= bus.mem_read_data;
                wpc_q[wr_ptr_q]  <= pc_q;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
        end
    end

    assign bus.mem_request       = mem_req_q;
    assign bus.mem_address       = mem_addr_q;
    assign bus.instruction       = word_q[rd_ptr_q];
    assign bus.instruction_pc    = wpc_q[rd_ptr_q];
    assign bus.instruction_valid = (count_q != '0);
    assign bus.misaligned_fault  = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a queue-based transaction model.
module tb_instruction_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } ent_t;

    logic clk;
    logic rst;
    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    ent_t        q[$];
    logic [31:0] exp_pc;
    bit          fault_m;
    bit          discarding;
    bit          have_prev;
    bit          prev_req;
    bit          prev_ack;
    bit          prev_redir;
    int          prev_cnt;
    logic [31:0] prev_addr;
    int          req_age;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[15:8] ^ 8'h5A, a[23:16], a[31:24] ^ 8'hC3} ^ 32'h0F1E_2D3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ack_ctl: >=0 ack after that many wait cycles, -1 random, -2 never, -3 always
    task automatic step(input bit rdy, input int ack_ctl, input bit redir, input logic [31:0] tgt);
        bit          ack;
        bit          ack_eff;
        bit          popped;
        bit          misal;
        int          cur_age;
        logic [31:0] t;
        @(negedge clk);
        check("valid", 32'(bus.instruction_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("instr", bus.instruction, q[0].word);
            check("instr_pc", bus.instruction_pc, q[0].pc);
        end
        check("fault", 32'(bus.misaligned_fault), 32'(fault_m));
        if (have_prev) begin
            check("req", 32'(bus.mem_request),
                  32'(prev_req ? !prev_ack : (prev_cnt < DEPTH && !prev_redir && !fault_m)));
            if (prev_req && bus.mem_request) check("addr_hold", bus.mem_address, prev_addr);
        end

        cur_age = bus.mem_request ? req_age : 0;
        case (ack_ctl)
            -1:      ack = ($urandom_range(99) < 35);
            -2:      ack = 1'b0;
            -3:      ack = 1'b1;
            default: ack = bus.mem_request && (cur_age >= ack_ctl);
        endcase
        req_age = (bus.mem_request && !ack) ? cur_age + 1 : 0;

        bus.instruction_ready = rdy;
        bus.mem_ack           = ack;
        bus.mem_read_data     = mem_word(bus.mem_address);
        bus.redirect          = redir;
        bus.redirect_target   = tgt;

        ack_eff    = ack && bus.mem_request;
        prev_req   = bus.mem_request;
        prev_ack   = ack_eff;
        prev_cnt   = q.size();
        prev_redir = redir;
        prev_addr  = bus.mem_address;
        have_prev  = 1'b1;

        if (redir && !fault_m) begin
            t     = tgt;
            misal = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            misal = (t[1:0] != 2'b00);
`else
            t[1:0] = 2'b00;
`endif
            q.delete();
            exp_pc     = t;
            discarding = bus.mem_request && !ack_eff;
            if (misal) fault_m = 1'b1;
        end else begin
            popped = (q.size() != 0) && rdy;
            if (popped) void'(q.pop_front());
            if (ack_eff) begin
                if (discarding) begin
                    discarding = 1'b0;
                end else begin
                    check("fetch_addr", bus.mem_address, exp_pc);
                    q.push_back('{word: mem_word(exp_pc), pc: exp_pc});
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst                   = 1'b1;
        bus.mem_ack           = 1'b1;
        bus.redirect          = 1'b0;
        bus.instruction_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req", 32'(bus.mem_request), 32'd0);
        check("rst_addr", bus.mem_address, RESET_PC);
        check("rst_valid", 32'(bus.instruction_valid), 32'd0);
        check("rst_instr", bus.instruction, 32'd0);
        check("rst_ipc", bus.instruction_pc, 32'd0);
        check("rst_fault", 32'(bus.misaligned_fault), 32'd0);
        rst        = 1'b0;
        q.delete();
        exp_pc     = RESET_PC;
        fault_m    = 1'b0;
        discarding = 1'b0;
        have_prev  = 1'b0;
        req_age    = 0;
    endtask

    task automatic run_random(input int n, input int ack_ctl, input int rdy_pct, input int redir_pct);
        logic [31:0] tgt;
        for (int i = 0; i < n; i++) begin
            tgt = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            step(int'($urandom_range(99)) < rdy_pct, ack_ctl,
                 int'($urandom_range(99)) < redir_pct, tgt);
        end
    endtask

    initial begin
        rst                   = 1'b1;
        bus.mem_ack           = 1'b0;
        bus.mem_read_data     = '0;
        bus.redirect          = 1'b0;
        bus.redirect_target   = '0;
        bus.instruction_ready = 1'b0;

        // streaming, one-cycle memory latency, decoder always ready
        do_reset();
        run_random(40, 1, 100, 0);

        // decoder stalled: FIFO fills, requests stop, then drains in order
        do_reset();
        run_random(10, 0, 0, 0);
        check("full_no_req", 32'(bus.mem_request), 32'd0);
        check("full_valid", 32'(bus.instruction_valid), 32'd1);
        run_random(30, 0, 100, 0);

        // redirect while the request to 0x8 is stuck
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_request && bus.mem_address == 32'h8) break;
            step(1'b1, 0, 1'b0, 32'h0);
        end
        check("pending_addr", bus.mem_address, 32'h8);
        step(1'b1, -2, 1'b0, 32'h0);
        step(1'b1, -2, 1'b0, 32'h0);
        step(1'b1, -2, 1'b1, 32'h100);
        check("redir_empty", 32'(bus.instruction_valid), 32'd0);
        check("redir_req_held", 32'(bus.mem_request), 32'd1);
        run_random(20, 0, 100, 0);

        // redirect coinciding with ack and pop
        do_reset();
        step(1'b0, 0, 1'b0, 32'h0);
        step(1'b0, 0, 1'b0, 32'h0);
        step(1'b0, 0, 1'b0, 32'h0);
        check("pre_valid", 32'(bus.instruction_valid), 32'd1);
        check("pre_req", 32'(bus.mem_request), 32'd1);
        step(1'b1, -3, 1'b1, 32'h200);
        check("coinc_empty", 32'(bus.instruction_valid), 32'd0);
        run_random(20, 0, 100, 0);

        // misaligned redirect target
        do_reset();
        run_random(6, 0, 100, 0);
        step(1'b1, -2, 1'b1, 32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
        check("fault_set", 32'(bus.misaligned_fault), 32'd1);
        run_random(20, 0, 100, 0);
        check("halt_no_req", 32'(bus.mem_request), 32'd0);
`else
        check("no_fault", 32'(bus.misaligned_fault), 32'd0);
        run_random(20, 0, 100, 0);
`endif

        // mixed random traffic with a reset in the middle
        do_reset();
        run_random(400, -1, 60, 4);
        run_random(300, 0, 50, 3);
        run_random(300, 2, 80, 5);
        do_reset();
        run_random(200, 1, 70, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage directly upstream of the instruction decoder. Holds the program counter and issues 32-bit word reads to instruction memory over a request/acknowledge handshake. Buffers returned words with their PCs in a small FIFO and presents them to the decoder with a valid/ready handshake. Accepts redirects (branch/jump targets) that flush buffered and in-flight instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- DEPTH, 2, instruction FIFO entries; power of two, 2..8
- Clock  in  1  sole clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- MemAddress  out  32  word address of current read; stable while MemRequest high and MemAck low
- MemRequest  out  1  read request; once raised, held until MemAck
- MemAck  in  1  completes request this cycle; MemReadData valid this cycle; may rise in same cycle as MemRequest
- MemReadData  in  32  returned instruction word
- Redirect  in  1  single-cycle pulse: restart fetch at RedirectTarget
- RedirectTarget  in  32  new PC
- Instruction  out  32  head-of-FIFO instruction, to decoder Instruction input
- InstructionPC  out  32  PC of Instruction
- InstructionValid  out  1  FIFO non-empty
- InstructionReady  in  1  decoder consumes head when Valid&Ready
- MisalignedFault  out  1  sticky alignment fault (see Configuration)

## Operation
- State: PC (32b), FIFO of {word, pc} × DEPTH, count (log2(DEPTH)+1 bits), FSM.
- FSM states: IDLE, WAIT, DISCARD, HALT.
- IDLE: if count < DEPTH (registered count, no same-cycle pop credit) -> raise MemRequest with MemAddress=PC, go WAIT.
- WAIT: on MemAck without Redirect -> push {MemReadData, PC}, PC += 4 (wraps modulo 2^32), go IDLE (re-requests next cycle if space).
- Redirect in IDLE: PC <= RedirectTarget, FIFO flushed, stay IDLE.
- Redirect in WAIT without MemAck: PC <= target, flush, go DISCARD; MemRequest and old MemAddress held.
- Redirect in WAIT with MemAck: data dropped, PC <= target, flush, go IDLE.
- DISCARD: on MemAck drop data, go IDLE; further Redirect updates PC only, stays DISCARD.
- Redirect with same-cycle pop: flush wins; pop has no further effect.
- Push and pop same cycle: count unchanged. Overflow impossible: request issued only when count < DEPTH, one request outstanding max.
- At most one outstanding memory request at all times.
- HALT: entered only via alignment fault (macro builds); MemRequest low, FIFO drains normally, exit only by Reset.

## Timing
- Reset values: PC=RESET_PC, MemAddress=RESET_PC, MemRequest=0, InstructionValid=0, Instruction=0, InstructionPC=0, MisalignedFault=0, count=0, FSM=IDLE.
- First MemRequest in first cycle after Reset deasserts.
- Word acked at edge N: InstructionValid high from cycle N+1 (registered FIFO output).
- Zero-wait memory (MemAck same cycle as request), decoder always ready: one request every other cycle (IDLE/WAIT alternate); 0.5 instr/cycle.
- Redirect at edge N: InstructionValid low in cycle N+1; request to target no earlier than cycle N+1 (IDLE) or first cycle after discarded ack (DISCARD).
- Reset mid-transaction: state returns to reset values next cycle; any in-flight ack afterwards ignored in IDLE.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: Redirect with RedirectTarget[1:0] != 2'b00 sets MisalignedFault (sticky until Reset), flushes FIFO, goes HALT (via DISCARD if request outstanding, then HALT on ack).
- Undefined: RedirectTarget[1:0] forced to 2'b00; MisalignedFault tied 0; HALT unreachable.

## Test plan
- Reset, memory acks 1 cycle after request, ready=1 -> Instruction/InstructionPC stream 0x0,0x4,0x8… matching memory contents, MemAddress never changes while request pending.
- InstructionReady=0 for 10 cycles -> exactly DEPTH words buffered, MemRequest low after, no loss or duplicate on release.
- Redirect to 0x100 while request to 0x8 pending 3 cycles -> 0x8 data dropped, next valid instruction has PC 0x100, FIFO empty in cycle after redirect.
- Redirect coincident with MemAck and pop -> acked word dropped, no pop, next fetch at target.
- Macro on: Redirect to 0x102 -> MisalignedFault=1, MemRequest stays 0 until Reset; macro off: fetch proceeds at 0x100.
